// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous byte FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH      = 8;

    // Pointers carry one extra wrap bit above the storage address.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register clears on reset and otherwise holds between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: wrap-bit pointers and flags here, storage in fifo_mem.
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // rst_n is active-high despite its name.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        wr_ok = w_en && !full && !rst_n;
        rd_ok = r_en && !empty && !rst_n;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst_n),
        .we   (wr_ok),
        .waddr(wr_ptr[ADDR_WIDTH-1:0]),
        .wdata(data_in),
        .re   (rd_ok),
        .raddr(rd_ptr[ADDR_WIDTH-1:0]),
        .rdata(data_out)
    );

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: vector table plus modelled multi-cycle sequences.
module tb_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_en    (w_en),
        .r_en    (r_en),
        .data_in (data_in),
        .data_out(data_out),
        .full    (full),
        .empty   (empty)
    );

    typedef struct {
        logic          rst;
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_do;
        logic          exp_e;
        logic          exp_f;
    } vec_t;

    vec_t vecs[$];

    // Reference model for the hand-written sequences.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_do = '0;

    function automatic vec_t mk(input logic rst, input logic w, input logic r,
                                input logic [DW-1:0] d, input logic [DW-1:0] exp_do,
                                input logic exp_e, input logic exp_f);
        vec_t v;
        v.rst = rst; v.w = w; v.r = r; v.d = d;
        v.exp_do = exp_do; v.exp_e = exp_e; v.exp_f = exp_f;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic w, input logic r, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_do, input logic exp_e, input logic exp_f,
                        input string tag);
        @(negedge clk);
        rst_n = rst; w_en = w; r_en = r; data_in = d;
        @(posedge clk);
        #1;
        cmp({tag, ".data_out"}, data_out, exp_do);
        cmp({tag, ".empty"}, DW'(empty), DW'(exp_e));
        cmp({tag, ".full"}, DW'(full), DW'(exp_f));
    endtask

    task automatic mstep(input logic rst, input logic w, input logic r, input logic [DW-1:0] d,
                         input string tag);
        bit do_rd, do_wr;
        if (rst) begin
            model_q.delete();
            model_do = '0;
        end else begin
            do_rd = r && (model_q.size() > 0);
            do_wr = w && (model_q.size() < DEPTH);
            if (do_rd) model_do = model_q.pop_front();
            if (do_wr) model_q.push_back(d);
        end
        step(rst, w, r, d, model_do, model_q.size() == 0, model_q.size() == DEPTH, tag);
    endtask

    initial begin
        // Reset, reads on empty, basic order, full boundary and drain.
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(1, 1, 1, 8'h55, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(0, 1, 0, 8'd10, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'd20, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'd30, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'd40, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'd10, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'd20, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'd30, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'd40, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'd40, 1, 0));
        for (int unsigned i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, DW'(i), 8'd40, 0, i == 8));
        vecs.push_back(mk(0, 1, 0, 8'd9, 8'd40, 0, 1));
        for (int unsigned i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 0, 1, 8'h00, DW'(i), i == 8, 0));

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].w, vecs[i].r, vecs[i].d,
                 vecs[i].exp_do, vecs[i].exp_e, vecs[i].exp_f, $sformatf("vec%0d", i));

        // Sync the model with the table's final state: empty, data_out = 8.
        model_q.delete();
        model_do = 8'd8;

        // Wrap-around: three full fill/drain rounds across the pointer wrap bit.
        for (int unsigned round = 0; round < 3; round++) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mstep(0, 1, 0, DW'(8'h60 + round * 16 + i), $sformatf("wrap%0d_w%0d", round, i));
            for (int unsigned i = 0; i < DEPTH; i++)
                mstep(0, 0, 1, 8'h00, $sformatf("wrap%0d_r%0d", round, i));
        end

        // Simultaneous access with 3 held, then at full, then at empty.
        for (int unsigned i = 0; i < 3; i++) mstep(0, 1, 0, DW'(8'hA0 + i), "sim_fill");
        for (int unsigned i = 0; i < 4; i++) mstep(0, 1, 1, DW'(8'hB0 + i), $sformatf("sim_rw%0d", i));
        for (int unsigned i = 0; i < 5; i++) mstep(0, 1, 0, DW'(8'hC0 + i), "sim_tofull");
        mstep(0, 1, 1, 8'hEE, "sim_rw_full");
        for (int unsigned i = 0; i < 7; i++) mstep(0, 0, 1, 8'h00, "sim_drain");
        mstep(0, 0, 0, 8'h00, "sim_empty");
        mstep(0, 1, 1, 8'h77, "sim_rw_empty");
        mstep(0, 0, 1, 8'h00, "sim_read_new");

        // Mid-operation reset abandons stored words.
        for (int unsigned i = 0; i < 5; i++) mstep(0, 1, 0, DW'(8'h10 + i), "mid_fill");
        mstep(1, 0, 0, 8'h00, "mid_rst");
        mstep(0, 1, 0, 8'hAA, "mid_wAA");
        mstep(0, 1, 0, 8'hBB, "mid_wBB");
        mstep(0, 0, 1, 8'h00, "mid_rAA");
        mstep(0, 0, 1, 8'h00, "mid_rBB");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in/first-out buffer for byte-wide data. It decouples a producer and a consumer that share one clock, using write-enable/read-enable strobes gated by full/empty flags. It sits between any two datapath stages that need elastic buffering without clock-domain crossing.

## Interface
- DATA_WIDTH, default 8: width of each stored word.
- DEPTH, default 8: number of entries; must be a power of two, minimum 2.
- ADDR_WIDTH, default $clog2(DEPTH): storage address width.

- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-high reset: asserted = 1, sampled only on the rising edge of clk.
- w_en  input  1  write request; data_in is stored on the rising edge when w_en=1 and full=0.
- r_en  input  1  read request; oldest entry is popped on the rising edge when r_en=1 and empty=0.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when DEPTH entries are held.
- empty  output  1  high when zero entries are held.

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset; contents are undefined until written.
- Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide; the low ADDR_WIDTH bits address storage and the MSB is a wrap bit.
- Accepted write: mem[wr_ptr low bits] <= data_in; wr_ptr increments modulo 2^(ADDR_WIDTH+1).
- Accepted read: data_out <= mem[rd_ptr low bits]; rd_ptr increments modulo 2^(ADDR_WIDTH+1).
- empty = (wr_ptr == rd_ptr).
- full = (low bits equal) and (MSBs differ).
- Flags are combinational from the pointer registers, so they change only after clock edges.
- Write while full: ignored; no storage change, no pointer change.
- Read while empty: ignored; data_out holds its previous value.
- Simultaneous w_en and r_en:
  - Neither full nor empty: both are performed and occupancy is unchanged.
  - Full: only the read is performed.
  - Empty: only the write is performed; data_out is not updated, and the new word is readable from the next cycle.
- data_out holds its last read value whenever no read is accepted.

## Timing
- Reset, with rst_n=1 on an edge:
  - wr_ptr and rd_ptr go to 0.
  - data_out goes to 0.
  - empty=1, full=0.
  - Any w_en/r_en in the same cycle is ignored.
- Reset takes effect mid-operation; stored data is abandoned and the FIFO reads as empty.
- Write-to-flag latency: 1 edge. empty falls right after the first accepted write edge.
- Read latency: data_out is valid right after the edge that accepts r_en; there is no additional cycle.
- A word written on edge N can be read on edge N+1 at the earliest.
- Full asserts right after the edge completing the DEPTH-th outstanding write. It deasserts right after the next accepted read.
- Pointer wrap-around is seamless: depth-indexed addressing continues past DEPTH with no bubble.

## Structure
- A shared package holds the default DATA_WIDTH/DEPTH constants and a pointer-width helper (ADDR_WIDTH+1).
- One sub-module is natural: fifo_mem, a simple dual-port register array with a write port (clk, we, waddr, wdata) and a synchronous read port (clk, re, raddr, rdata).
- Pointer logic and flags live in the top-level fifo.

## Test plan
- Reset: hold rst_n=1 for 2 edges → data_out=0, empty=1, full=0.
  - Release reset, then assert r_en for 2 edges → data_out stays 0 and empty stays 1.
- Basic order: write 10, 20, 30, 40 on four consecutive edges, idle 2 cycles, then r_en for 5 edges.
  - data_out reads 10, 20, 30, 40 in order.
  - empty rises after the 4th read.
  - The 5th read is ignored and data_out holds 40.
- Full boundary (DEPTH=8): write 1..9 on consecutive edges → full rises after the 8th write and the 9th write is dropped.
  - Reading 8 times returns 1..8, then empty=1.
- Wrap-around: write 8 and read 8, three times over with incrementing data → every read matches its write, with no stale data or spurious flags across pointer wrap.
- Simultaneous access:
  - With 3 entries held, assert w_en and r_en for 4 edges → occupancy stays 3 and outputs stay in FIFO order.
  - When full with both asserted → only the read happens and full drops.
  - When empty with both asserted → only the write happens and empty drops.
- Mid-operation reset: write 5 words, assert rst_n for 1 edge → empty=1, full=0, data_out=0.
  - Subsequent writes of 0xAA and 0xBB read back as 0xAA, 0xBB.
